// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 signed multiplier among NUM_REQ requesters.
// Define MULT_RR_STATS_EN to add the ops_done / stall_cycles statistics outputs.

module four_bit_signed_multiplier (
    input  logic signed [3:0] a,
    input  logic signed [3:0] b,
    output logic signed [7:0] product
);
    assign product = a * b;
endmodule

module mult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic signed [7:0]      rsp_product,
    output logic                   busy
`ifdef MULT_RR_STATS_EN
    ,
    output logic [15:0]            ops_done,
    output logic [15:0]            stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    last_grant, grant_idx, id_p0;
    logic               grant_vld, accept;
    logic signed [3:0]  sel_a, sel_b, op_a_p0, op_b_p0;
    logic signed [7:0]  mul_out;

    // Rotating search: first valid requester after last_grant wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(last_grant) + 1 + k) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_vld && (j == idx) && req_valid[j]) begin
                    grant_vld = 1'b1;
                    grant_idx = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == ID_W'(j)) begin
                sel_a = req_a[4*j +: 4];
                sel_b = req_b[4*j +: 4];
            end
            req_ready[j] = (state == IDLE) && grant_vld && (grant_idx == ID_W'(j));
        end
    end

    assign accept    = (state == IDLE) && grant_vld;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = MUL;
            MUL:                    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    four_bit_signed_multiplier u_mul (
        .a       (op_a_p0),
        .b       (op_b_p0),
        .product (mul_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            op_a_p0     <= '0;
            op_b_p0     <= '0;
            id_p0       <= '0;
            rsp_product <= '0;
            rsp_id      <= '0;
        end else begin
            state <= state_nxt;
            // p0: operands captured on the request handshake
            if (accept) begin
                op_a_p0    <= sel_a;
                op_b_p0    <= sel_b;
                id_p0      <= grant_idx;
                last_grant <= grant_idx;
            end
            // p1: product registered, held through RESP until consumed
            if (state == MUL) begin
                rsp_product <= mul_out;
                rsp_id      <= id_p0;
            end
        end
    end

`ifdef MULT_RR_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done     <= '0;
            stall_cycles <= '0;
        end else if (state == RESP) begin
            if (rsp_ready) ops_done     <= sat_inc(ops_done);
            else           stall_cycles <= sat_inc(stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed self-checking bench for mult_rr_scheduler (NUM_REQ=4, ID_W=2).

module tb_mult_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_product;
    logic        busy;
`ifdef MULT_RR_STATS_EN
    logic [15:0] ops_done;
    logic [15:0] stall_cycles;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    mult_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_product  (rsp_product),
        .busy         (busy)
`ifdef MULT_RR_STATS_EN
        ,
        .ops_done     (ops_done),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick();
        tick();
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); else pass_cnt++;
        total_cnt++; if (rsp_product !== 8'h00) $display("FAIL reset_rsp_product: got %h expected 00", rsp_product); else pass_cnt++;
`ifdef MULT_RR_STATS_EN
        total_cnt++; if (ops_done !== 16'd0) $display("FAIL reset_ops_done: got %0d expected 0", ops_done); else pass_cnt++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_op(0, 4'd3, 4'hE);
        req_valid = 4'b0001;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready); else pass_cnt++;
        tick();
        req_valid = '0;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_mul_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_mul_busy: got %b expected 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_product !== 8'hFA) $display("FAIL single_product: got %h expected fa", rsp_product); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL single_id: got %0d expected 0", rsp_id); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_done: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else pass_cnt++;
    endtask

    task automatic test_extremes();
        logic [3:0] va [3] = '{4'h8, 4'h8, 4'h7};
        logic [3:0] vb [3] = '{4'h8, 4'h7, 4'h7};
        logic [7:0] vp [3] = '{8'h40, 8'hC8, 8'h31};
        for (int t = 0; t < 3; t++) begin
            set_op(2, va[t], vb[t]);
            req_valid = 4'b0100;
            #1;
            total_cnt++; if (req_ready !== 4'b0100) $display("FAIL extreme_ready[%0d]: got %b expected 0100", t, req_ready); else pass_cnt++;
            tick();
            req_valid = '0;
            tick();
            total_cnt++; if (rsp_valid !== 1'b1 || rsp_product !== vp[t] || rsp_id !== 2'd2)
                $display("FAIL extreme_rsp[%0d]: got valid=%b prod=%h id=%0d expected 1 %h 2", t, rsp_valid, rsp_product, rsp_id, vp[t]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_p [4] = '{8'h02, 8'hF4, 8'hFB, 8'h2A};
        logic [3:0] er;
        apply_reset();
        set_op(0, 4'd1, 4'd2);
        set_op(1, 4'hD, 4'd4);
        set_op(2, 4'd5, 4'hF);
        set_op(3, 4'h9, 4'hA);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 6; g++) begin
            er = 4'b0001 << (g % 4);
            total_cnt++; if (req_ready !== er) $display("FAIL rr_grant[%0d]: got %b expected %b", g, req_ready, er); else pass_cnt++;
            tick();
            total_cnt++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) $display("FAIL rr_mul[%0d]: got ready=%b valid=%b expected 0000 0", g, req_ready, rsp_valid); else pass_cnt++;
            tick();
            total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g % 4) || rsp_product !== exp_p[g % 4])
                $display("FAIL rr_rsp[%0d]: got valid=%b id=%0d prod=%h expected 1 %0d %h", g, rsp_valid, rsp_id, rsp_product, g % 4, exp_p[g % 4]);
            else pass_cnt++;
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_op(0, 4'd2, 4'd3);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++; if (rsp_valid !== 1'b1 || rsp_product !== 8'h06 || rsp_id !== 2'd0)
                $display("FAIL bp_hold[%0d]: got valid=%b prod=%h id=%0d expected 1 06 0", i, rsp_valid, rsp_product, rsp_id);
            else pass_cnt++;
            total_cnt++; if (req_ready !== 4'b0000 || busy !== 1'b1) $display("FAIL bp_blocked[%0d]: got ready=%b busy=%b expected 0000 1", i, req_ready, busy); else pass_cnt++;
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_still_valid: got %b expected 1", rsp_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else pass_cnt++;
`ifdef MULT_RR_STATS_EN
        total_cnt++; if (stall_cycles !== 16'd5) $display("FAIL bp_stall_cycles: got %0d expected 5", stall_cycles); else pass_cnt++;
        total_cnt++; if (ops_done !== 16'd1) $display("FAIL bp_ops_done: got %0d expected 1", ops_done); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_op();
        int seen;
        seen = 0;
        set_op(1, 4'd3, 4'd3);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_in_mul: got busy=%b expected 1", busy); else pass_cnt++;
        apply_reset();
        total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_after: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid === 1'b1) seen++;
            tick();
        end
        total_cnt++; if (seen !== 0) $display("FAIL midrst_no_result: got %0d valid cycles expected 0", seen); else pass_cnt++;
        set_op(0, 4'd1, 4'd1);
        set_op(3, 4'd1, 4'd1);
        req_valid = 4'b1001;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL midrst_prio: got %b expected 0001", req_ready); else pass_cnt++;
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_sparse();
        set_op(1, 4'hF, 4'hF);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        set_op(3, 4'd4, 4'hC);
        req_valid = 4'b1000;
        #1;
        total_cnt++; if (req_ready !== 4'b1000) $display("FAIL sparse_grant3: got %b expected 1000", req_ready); else pass_cnt++;
        tick();
        req_valid = '0;
        tick();
        total_cnt++; if (rsp_id !== 2'd3 || rsp_product !== 8'hF0) $display("FAIL sparse_rsp: got id=%0d prod=%h expected 3 f0", rsp_id, rsp_product); else pass_cnt++;
        tick();
        req_valid = 4'b1001;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL sparse_next: got %b expected 0001", req_ready); else pass_cnt++;
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_sparse();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
